// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU issuer: op codes, FSM state encoding,
// and the response bundle used on both the sample and response paths.
package alu_issuer_pkg;

    // Native ALU commands (values fixed by the existing ALU)
    localparam logic [2:0] opADD     = 3'd0;
    localparam logic [2:0] opSUB     = 3'd1;
    localparam logic [2:0] opXOR     = 3'd2;
    localparam logic [2:0] opSLT     = 3'd3;
    localparam logic [2:0] opCNE     = 3'd4;
    // Composite ops built by the issuer from SLT and SUB
    localparam logic [2:0] opMIN     = 3'd5;
    localparam logic [2:0] opMAX     = 3'd6;
    localparam logic [2:0] opABSDIFF = 3'd7;

    // Issuer FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE1 = 2'd1;
    localparam logic [1:0] ST_SETTLE2 = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef struct packed {
        logic [31:0] result;
        logic        carryout;
        logic        zero;
        logic        overflow;
    } alu_rsp_t;

    // Composite ops always start with an SLT pass
    function automatic logic is_composite(input logic [2:0] op);
        return (op >= opMIN);
    endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Settle counter for one ALU pass. Cleared on pass entry, counts up while
// enabled. o_sample fires when the ALU inputs have been stable for SETTLE
// cycles; o_done fires one cycle later, when the sampled values are ready.
module alu_settle_timer #(
    parameter int SETTLE = 4,
    parameter int CW     = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_sample,
    output logic o_done
);

    localparam logic [CW-1:0] L_SAMPLE = CW'(SETTLE - 1);
    localparam logic [CW-1:0] L_DONE   = CW'(SETTLE);

    logic [CW-1:0] r_count;

    // Up-count from pass entry; parks at the done value until reloaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != L_DONE)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_sample = i_en && (r_count == L_SAMPLE);
    assign o_done   = i_en && (r_count == L_DONE);

endmodule

// File: rtl/alu_issuer.sv
// Sequencing front-end for the combinational 32-bit ALU.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// SETTLE1  | first pass driven (native op, or SLT for composites)
// SETTLE2  | ABSDIFF second pass: SUB(larger, smaller)
// RESP     | response held on rsp_* until rsp_ready
//
// A pass samples the ALU after SETTLE stable cycles. ABSDIFF launches its
// SUB pass on that same edge using the live SLT bit, so it adds exactly
// SETTLE cycles; every op then spends one cycle building the response from
// the sampled registers.
module alu_issuer
    import alu_issuer_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int CW     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [2:0]  alu_command,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carryout,
    output logic        rsp_zero,
    output logic        rsp_overflow
);

    logic [1:0]  r_state;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_alu_cmd;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    alu_rsp_t    r_samp;
    alu_rsp_t    r_rsp;
    logic        r_rsp_valid;

    alu_rsp_t    w_alu_now;
    alu_rsp_t    w_rsp_next;
    logic        w_accept;
    logic        w_pass2;
    logic        w_settling;
    logic        w_sample;
    logic        w_done;

    assign w_alu_now  = {alu_result, alu_carryout, alu_zero, alu_overflow};
    assign w_settling = (r_state == ST_SETTLE1) || (r_state == ST_SETTLE2);
    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_pass2    = (r_state == ST_SETTLE1) && w_sample && (r_op == opABSDIFF);

    alu_settle_timer #(
        .SETTLE (SETTLE),
        .CW     (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept || w_pass2),
        .i_en     (w_settling),
        .o_sample (w_sample),
        .o_done   (w_done)
    );

    // Next-state sequencing between passes and the response phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (req_valid) r_state <= ST_SETTLE1;
                ST_SETTLE1: begin
                    if (w_pass2)     r_state <= ST_SETTLE2;
                    else if (w_done) r_state <= ST_RESP;
                end
                ST_SETTLE2: if (w_done) r_state <= ST_RESP;
                ST_RESP:    if (rsp_ready) r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Hold the accepted request for composite result selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
        end
    end

    // ALU drive registers change only when a pass is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_cmd <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else if (w_accept) begin
            r_alu_cmd <= is_composite(req_op) ? opSLT : req_op;
            r_alu_a   <= req_a;
            r_alu_b   <= req_b;
        end else if (w_pass2) begin
            // alu_result[0] is the live SLT(a,b) bit: subtract smaller from larger
            r_alu_cmd <= opSUB;
            r_alu_a   <= alu_result[0] ? r_b : r_a;
            r_alu_b   <= alu_result[0] ? r_a : r_b;
        end
    end

    // Capture ALU outputs once they have settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= '0;
        end else if (w_sample) begin
            r_samp <= w_alu_now;
        end
    end

    // Response selection: MIN/MAX pick an operand from the SLT bit, flags cleared
    always_comb begin
        w_rsp_next = r_samp;
        case (r_op)
            opMIN: begin
                w_rsp_next        = '0;
                w_rsp_next.result = r_samp.result[0] ? r_a : r_b;
            end
            opMAX: begin
                w_rsp_next        = '0;
                w_rsp_next.result = r_samp.result[0] ? r_b : r_a;
            end
            default: w_rsp_next = r_samp;
        endcase
    end

    // Response register and valid flag, held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else if (w_settling && w_done) begin
            r_rsp       <= w_rsp_next;
            r_rsp_valid <= 1'b1;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign alu_command  = r_alu_cmd;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp.result;
    assign rsp_carryout = r_rsp.carryout;
    assign rsp_zero     = r_rsp.zero;
    assign rsp_overflow = r_rsp.overflow;

endmodule
